// File: rtl/blood_pkg.sv
// blood_pkg: shared widths, the sample record and the sequencer state type
// for the blood sample sequencer and its FIFO.
package blood_pkg;

  localparam int PH_W   = 4;
  localparam int TYPE_W = 3;
  localparam int CNT_W  = 8;

  // One buffered sample. The type field is called btype because "type" is a
  // reserved word.
  typedef struct packed {
    logic [PH_W-1:0]   ph;
    logic [TYPE_W-1:0] btype;
  } blood_sample_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    REPORT = 2'd2
  } seq_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/blood_sample_fifo.sv
// blood_sample_fifo: DEPTH-entry FIFO of blood_sample_t with first-word
// fall-through head. Full/empty come from a registered occupancy counter one
// bit wider than the pointers. A push while full is refused even if a pop
// happens in the same cycle.
module blood_sample_fifo
  import blood_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  blood_sample_t i_data,
  output logic          o_full,
  input  logic          i_pop,
  output blood_sample_t o_head,
  output logic          o_empty
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

  blood_sample_t r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == LP_FULL);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];

  // Sample storage; contents are only meaningful between the pointers.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally modulo DEPTH; occupancy tracks full vs empty.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/blood_sample_sequencer.sv
// blood_sample_sequencer: pops buffered samples, holds each on the detector
// inputs for DWELL_CYCLES cycles, captures the detector verdict on the last
// dwell edge and returns it with the sample on a valid/ready result port.
// Define BLOOD_SEQ_STATS_EN to build the saturating result counters;
// otherwise abnormal_count/total_count read 0.
module blood_sample_sequencer
  import blood_pkg::*;
#(
  parameter int DWELL_CYCLES = 4,
  parameter int DEPTH        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [PH_W-1:0]   wr_ph,
  input  logic [TYPE_W-1:0] wr_type,
  output logic [PH_W-1:0]   bloodPH,
  output logic [TYPE_W-1:0] bloodType,
  input  logic              bloodAbnormality,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [PH_W-1:0]   res_ph,
  output logic [TYPE_W-1:0] res_type,
  output logic              res_abnormal,
  output logic              busy,
  output logic [CNT_W-1:0]  abnormal_count,
  output logic [CNT_W-1:0]  total_count
);

  localparam logic [7:0] LP_DWELL_LOAD = 8'(DWELL_CYCLES - 1);

  seq_state_t    r_state;
  logic [7:0]    r_dwell;
  blood_sample_t r_drv;
  blood_sample_t r_res;
  logic          r_res_valid;
  logic          r_res_abnormal;

  blood_sample_t w_wr_sample;
  blood_sample_t w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;

  assign w_wr_sample = '{ph: wr_ph, btype: wr_type};

  // A new sample is taken only from IDLE, so the detector inputs never
  // change while a result is outstanding.
  assign w_pop = (r_state == IDLE) && !w_empty;

  blood_sample_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_push  (wr_valid),
    .i_data  (w_wr_sample),
    .o_full  (w_full),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_empty)
  );

  assign wr_ready     = !w_full;
  assign bloodPH      = r_drv.ph;
  assign bloodType    = r_drv.btype;
  assign res_valid    = r_res_valid;
  assign res_ph       = r_res.ph;
  assign res_type     = r_res.btype;
  assign res_abnormal = r_res_abnormal;
  assign busy         = (r_state != IDLE) || !w_empty;

  // Sequencing FSM: fetch, dwell, then hold the result until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_dwell        <= '0;
      r_drv          <= '0;
      r_res          <= '0;
      r_res_valid    <= 1'b0;
      r_res_abnormal <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_drv   <= w_head;
            r_dwell <= LP_DWELL_LOAD;
            r_state <= DRIVE;
          end
        end
        DRIVE: begin
          // Verdict is sampled only here, so earlier detector glitches
          // during the dwell have no effect.
          if (r_dwell == 8'd0) begin
            r_res          <= r_drv;
            r_res_abnormal <= bloodAbnormality;
            r_res_valid    <= 1'b1;
            r_state        <= REPORT;
          end else begin
            r_dwell <= r_dwell - 8'd1;
          end
        end
        REPORT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef BLOOD_SEQ_STATS_EN
  logic [CNT_W-1:0] r_abn_cnt;
  logic [CNT_W-1:0] r_tot_cnt;
  logic             w_res_accept;

  assign w_res_accept   = r_res_valid && res_ready;
  assign abnormal_count = r_abn_cnt;
  assign total_count    = r_tot_cnt;

  // Saturating statistics, updated on each accepted result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_abn_cnt <= '0;
      r_tot_cnt <= '0;
    end else if (w_res_accept) begin
      r_tot_cnt <= sat_inc(r_tot_cnt);
      if (r_res_abnormal) begin
        r_abn_cnt <= sat_inc(r_abn_cnt);
      end
    end
  end
`else
  assign abnormal_count = '0;
  assign total_count    = '0;
`endif

endmodule

// File: tb/tb_blood_sample_sequencer.sv
// tb_blood_sample_sequencer: table-driven single-sample vectors, directed
// multi-cycle sequences, and a randomized run scored against a queue model.
`timescale 1ns/1ps
module tb_blood_sample_sequencer;

  localparam int DWELL = 4;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [3:0] wr_ph = '0;
  logic [2:0] wr_type = '0;
  logic [3:0] bloodPH;
  logic [2:0] bloodType;
  logic       bloodAbnormality;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [3:0] res_ph;
  logic [2:0] res_type;
  logic       res_abnormal;
  logic       busy;
  logic [7:0] abnormal_count;
  logic [7:0] total_count;

  logic det_mode = 1'b0;
  logic glitch_val = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int exp_total = 0;
  int exp_abn = 0;

  typedef struct {
    logic [3:0] ph;
    logic [2:0] ty;
    logic       ab;
  } vec_t;

  typedef struct {
    logic [3:0] ph;
    logic [2:0] ty;
  } smp_t;

  vec_t vt[8];
  smp_t q[$];

  // Detector stand-in: abnormal when pH code is out of 4..10 or type is 7.
  function automatic logic ref_abnormal(input logic [3:0] ph, input logic [2:0] ty);
    return (ph < 4'd4) || (ph > 4'd10) || (ty == 3'd7);
  endfunction

  assign bloodAbnormality = det_mode ? glitch_val : ref_abnormal(bloodPH, bloodType);

  blood_sample_sequencer #(
    .DWELL_CYCLES(DWELL),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ph(wr_ph), .wr_type(wr_type),
    .bloodPH(bloodPH), .bloodType(bloodType), .bloodAbnormality(bloodAbnormality),
    .res_valid(res_valid), .res_ready(res_ready), .res_ph(res_ph),
    .res_type(res_type), .res_abnormal(res_abnormal), .busy(busy),
    .abnormal_count(abnormal_count), .total_count(total_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_accept(input logic ab);
    if (exp_total < 255) exp_total++;
    if (ab && exp_abn < 255) exp_abn++;
  endtask

  task automatic check_counts(input string tag);
`ifdef BLOOD_SEQ_STATS_EN
    check({tag, "_total"}, total_count, exp_total);
    check({tag, "_abn"}, abnormal_count, exp_abn);
`else
    check({tag, "_total"}, total_count, 0);
    check({tag, "_abn"}, abnormal_count, 0);
`endif
  endtask

  task automatic wait_res();
    int i;
    i = 0;
    while (!res_valid && i < 200) begin
      step();
      i++;
    end
    if (!res_valid) check("res_timeout", res_valid, 1);
  endtask

  // Waits for a result (res_ready must already be 1) and scores it.
  task automatic expect_result(input logic [3:0] ph, input logic [2:0] ty);
    wait_res();
    check("drain_ph", res_ph, ph);
    check("drain_type", res_type, ty);
    check("drain_abn", res_abnormal, ref_abnormal(ph, ty));
    step();
    model_accept(ref_abnormal(ph, ty));
  endtask

  task automatic run_single(input vec_t v);
    wr_ph = v.ph; wr_type = v.ty; wr_valid = 1'b1;
    step();                                  // push edge N
    wr_valid = 1'b0;
    step();                                  // N+1: popped onto detector
    check("drive_ph", bloodPH, v.ph);
    check("drive_type", bloodType, v.ty);
    check("drive_busy", busy, 1);
    for (int k = 1; k < DWELL; k++) step();  // N+DWELL
    check("early_valid", res_valid, 0);
    step();                                  // N+1+DWELL: capture
    check("res_valid", res_valid, 1);
    check("res_ph", res_ph, v.ph);
    check("res_type", res_type, v.ty);
    check("res_abn", res_abnormal, v.ab);
    step();                                  // handshake
    model_accept(v.ab);
    check("post_valid", res_valid, 0);
    check("post_busy", busy, 0);
    check_counts("single");
  endtask

  task automatic run_glitch(input logic [3:0] ph, input logic [2:0] ty,
                            input logic early, input logic fin, input logic exp_ab);
    det_mode = 1'b1;
    wr_ph = ph; wr_type = ty; wr_valid = 1'b1;
    step();                                  // N
    wr_valid = 1'b0;
    glitch_val = early;
    step();                                  // N+1
    for (int k = 1; k < DWELL; k++) step();  // N+DWELL
    glitch_val = fin;
    step();                                  // capture edge
    glitch_val = 1'b0;
    check("glitch_valid", res_valid, 1);
    check("glitch_abn", res_abnormal, exp_ab);
    step();
    model_accept(exp_ab);
    det_mode = 1'b0;
    check_counts("glitch");
  endtask

  initial begin
    logic [3:0] hph;
    logic [2:0] hty;
    logic       hab;
    logic       hold;
    smp_t       s;
    int         pushed;
    int         got;
    int         seen;

    vt[0] = '{4'd7,  3'd4, 1'b0};
    vt[1] = '{4'd2,  3'd0, 1'b1};
    vt[2] = '{4'd12, 3'd5, 1'b1};
    vt[3] = '{4'd9,  3'd7, 1'b1};
    vt[4] = '{4'd5,  3'd2, 1'b0};
    vt[5] = '{4'd10, 3'd6, 1'b0};
    vt[6] = '{4'd4,  3'd1, 1'b0};
    vt[7] = '{4'd3,  3'd3, 1'b1};

    // Reset state
    rst_n = 1'b0;
    step(); step();
    check("rst_bloodPH", bloodPH, 0);
    check("rst_bloodType", bloodType, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_ph", res_ph, 0);
    check("rst_res_type", res_type, 0);
    check("rst_res_abn", res_abnormal, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_ready", wr_ready, 1);
    check_counts("rst");
    rst_n = 1'b1;
    res_ready = 1'b1;
    step();

    // Table-driven single samples
    for (int i = 0; i < 8; i++) run_single(vt[i]);

    // Verdict sampling only at the last dwell edge
    run_glitch(4'd2, 3'd0, 1'b0, 1'b1, 1'b1);
    run_glitch(4'd2, 3'd0, 1'b1, 1'b0, 1'b0);
    run_glitch(4'd7, 3'd4, 1'b0, 1'b1, 1'b1);

    // Backpressure
    res_ready = 1'b0;
    wr_ph = 4'd6; wr_type = 3'd1; wr_valid = 1'b1;
    step();
    wr_ph = 4'd3; wr_type = 3'd2;
    step();
    wr_valid = 1'b0;
    wait_res();
    for (int k = 0; k < 10; k++) begin
      step();
      check("bp_valid", res_valid, 1);
      check("bp_res", {res_ph, res_type, res_abnormal}, {4'd6, 3'd1, 1'b0});
      check("bp_drive", {bloodPH, bloodType}, {4'd6, 3'd1});
    end
    res_ready = 1'b1;
    step();
    model_accept(1'b0);
    check("bp_hs_valid", res_valid, 0);
    check("bp_hs_drive", bloodPH, 4'd6);
    step();
    check("bp_next_drive", {bloodPH, bloodType}, {4'd3, 3'd2});
    expect_result(4'd3, 3'd2);
    check_counts("bp");

    // Full FIFO: a pending result blocks popping while DEPTH+1 pushes arrive
    res_ready = 1'b0;
    wr_ph = 4'd8; wr_type = 3'd0; wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    wait_res();
    for (int i = 0; i <= DEPTH; i++) begin
      check("fill_wr_ready", wr_ready, (i < DEPTH) ? 1 : 0);
      wr_ph = 4'((i + 5) % 16); wr_type = 3'(i % 8); wr_valid = 1'b1;
      step();
    end
    wr_valid = 1'b0;
    check("full_wr_ready", wr_ready, 0);
    check("full_busy", busy, 1);
    check("full_blocker", {res_valid, res_ph}, {1'b1, 4'd8});
    res_ready = 1'b1;
    expect_result(4'd8, 3'd0);
    for (int i = 0; i < DEPTH; i++) expect_result(4'((i + 5) % 16), 3'(i % 8));
    check("full_drained_busy", busy, 0);
    check("full_drained_valid", res_valid, 0);
    check_counts("full");

    // Randomized traffic against the queue model
    hold = 1'b0; hph = '0; hty = '0; hab = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (hold) check("rnd_stable", {res_valid, res_ph, res_type, res_abnormal},
                      {1'b1, hph, hty, hab});
      if (res_valid && res_ready) begin
        if (q.size() == 0) begin
          check("rnd_spurious", res_valid, 0);
        end else begin
          s = q.pop_front();
          check("rnd_ph", res_ph, s.ph);
          check("rnd_type", res_type, s.ty);
          check("rnd_abn", res_abnormal, ref_abnormal(s.ph, s.ty));
          model_accept(ref_abnormal(s.ph, s.ty));
        end
      end
      hold = res_valid && !res_ready;
      hph = res_ph; hty = res_type; hab = res_abnormal;
      if (wr_valid && wr_ready) q.push_back('{wr_ph, wr_type});
      step();
      wr_valid  = ($urandom_range(0, 3) != 0);
      wr_ph     = 4'($urandom);
      wr_type   = 3'($urandom);
      res_ready = ($urandom_range(0, 2) != 0);
    end
    if (wr_valid && wr_ready) q.push_back('{wr_ph, wr_type});
    wr_valid = 1'b0;
    res_ready = 1'b1;
    for (int c = 0; c < 2000 && q.size() > 0; c++) begin
      if (res_valid) begin
        s = q.pop_front();
        check("rnd_drain_ph", res_ph, s.ph);
        check("rnd_drain_type", res_type, s.ty);
        check("rnd_drain_abn", res_abnormal, ref_abnormal(s.ph, s.ty));
        model_accept(ref_abnormal(s.ph, s.ty));
      end
      step();
    end
    check("rnd_left", q.size(), 0);
    check("rnd_busy", busy, 0);
    check_counts("rnd");

    // Reset in the middle of DRIVE with three samples queued
    for (int i = 0; i < 4; i++) begin
      wr_ph = 4'(i + 1); wr_type = 3'(i); wr_valid = 1'b1;
      step();
    end
    wr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_bloodPH", bloodPH, 0);
    check("mid_rst_bloodType", bloodType, 0);
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_res", {res_ph, res_type, res_abnormal}, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_wr_ready", wr_ready, 1);
    exp_total = 0; exp_abn = 0;
    check_counts("mid_rst");
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (res_valid || busy) seen++;
    end
    check("mid_rst_quiet", seen, 0);

    // Saturation of the statistics counters
    pushed = 0; got = 0;
    for (int c = 0; c < 5000 && got < 300; c++) begin
      wr_valid = (pushed < 300);
      wr_ph = 4'd1;
      wr_type = 3'($urandom);
      if (wr_valid && wr_ready) pushed++;
      if (res_valid && res_ready) begin
        got++;
        check("sat_abn", res_abnormal, 1);
        model_accept(1'b1);
      end
      step();
    end
    wr_valid = 1'b0;
    check("sat_results", got, 300);
    check_counts("sat");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
